// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, handshake
// levels and the iteration-counter width helper.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree = 2'b00,
        DivOn   = 2'b01,
        DivEnd  = 2'b10
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Counter width: enough to hold 0..w, i.e. $clog2(w)+1 bits.
    function automatic int div_cnt_bus(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    // One extra guard bit so the borrow of the trial subtraction is always visible.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {2'b00, i_divisor};
        o_qbit  = ~w_diff[WIDTH+1];
        o_rem   = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider producing {remainder, quotient}
// for a HI/LO write; one restoring step per cycle, abortable through annul_i.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_div_i,
    input  logic                 annul_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CNT_W = div_cnt_bus(WIDTH);

    div_state_e           r_state;
    div_state_e           w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_quot;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_accept;
    logic                 w_div_zero;
    logic                 w_neg1;
    logic                 w_neg2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic                 w_last;
    logic [WIDTH:0]       w_rem;
    logic                 w_qbit;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_q_fix;
    logic [WIDTH-1:0]     w_r_fix;

    always_comb begin
        w_accept   = (start_i == DivStart) && !annul_i;
        w_div_zero = (opdata2_i == '0);
        w_neg1     = signed_div_i & opdata1_i[WIDTH-1];
        w_neg2     = signed_div_i & opdata2_i[WIDTH-1];
        w_mag1     = w_neg1 ? ('0 - opdata1_i) : opdata1_i;
        w_mag2     = w_neg2 ? ('0 - opdata2_i) : opdata2_i;
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_dvs),
        .i_bit     (r_dvd[WIDTH-1]),
        .o_rem     (w_rem),
        .o_qbit    (w_qbit)
    );

    // Sign fixup is applied to the final step's combinational output so the
    // corrected result is already registered when DivEnd is entered.
    always_comb begin
        w_quot  = {r_quot[WIDTH-2:0], w_qbit};
        w_q_fix = r_neg_q ? ('0 - w_quot) : w_quot;
        w_r_fix = r_neg_r ? ('0 - w_rem[WIDTH-1:0]) : w_rem[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DivFree;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DivFree: if (w_accept) w_next = w_div_zero ? DivEnd : DivOn;
            DivOn: begin
                if (annul_i)     w_next = DivFree;
                else if (w_last) w_next = DivEnd;
            end
            DivEnd:  w_next = DivFree;
            default: w_next = DivFree;
        endcase
    end

    always_comb begin
        ready_o = (r_state == DivEnd) ? DivResultReady : DivResultNotReady;
        busy_o  = (r_state != DivFree);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_quot   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                DivFree: begin
                    if (w_accept) begin
                        r_neg_q <= w_neg1 ^ w_neg2;
                        r_neg_r <= w_neg1;
                        if (w_div_zero) begin
                            r_result <= '0;
                        end else begin
                            r_dvd  <= w_mag1;
                            r_dvs  <= w_mag2;
                            r_cnt  <= '0;
                            r_rem  <= '0;
                            r_quot <= '0;
                        end
                    end
                end
                DivOn: begin
                    if (!annul_i) begin
                        r_rem  <= w_rem;
                        r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
                        r_quot <= w_quot;
                        if (w_last) begin
                            r_cnt    <= '0;
                            r_result <= {w_r_fix, w_q_fix};
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {rem, quot}, monitors
// pop and compare on every ready pulse; timing of ready/busy checked inline.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32 = 1'b0, sgn32 = 1'b0, annul32 = 1'b0;
    logic [31:0] op1_32 = '0, op2_32 = '0;
    logic [63:0] res32;
    logic        ready32, busy32;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  op1_8 = '0, op2_8 = '0;
    logic [15:0] res8;
    logic        ready8, busy8;

    logic [63:0] q32[$];
    logic [15:0] q8[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .signed_div_i(sgn32),
        .annul_i(annul32), .opdata1_i(op1_32), .opdata2_i(op2_32),
        .result_o(res32), .ready_o(ready32), .busy_o(busy32)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .signed_div_i(sgn8),
        .annul_i(1'b0), .opdata1_i(op1_8), .opdata2_i(op2_8),
        .result_o(res8), .ready_o(ready8), .busy_o(busy8)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready32) begin
            if (q32.size() == 0) check("ready32_unexpected", 64'd1, 64'd0);
            else check("result32", res32, q32.pop_front());
        end
        if (ready8) begin
            if (q8.size() == 0) check("ready8_unexpected", 64'd1, 64'd0);
            else check("result8", {48'd0, res8}, {48'd0, q8.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return '0;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, q, r;
        logic [31:0] qv, rv;
        if (b == 8'd0) return '0;
        sa = s ? int'($signed(a)) : int'({24'd0, a});
        sb = s ? int'($signed(b)) : int'({24'd0, b});
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[7:0], qv[7:0]};
    endfunction

    // Issues one 32-bit division from DivFree and checks ready/busy timing;
    // returns in the first DivFree cycle after completion.
    task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat);
        int got = -1;
        int rcnt = 0;
        int busy_bad = 0;
        sgn32 = s; op1_32 = a; op2_32 = b; start32 = 1'b1;
        q32.push_back(exp);
        tick();
        start32 = 1'b0;
        for (int k = 1; k <= lat + 1; k++) begin
            if (ready32) begin
                rcnt++;
                if (got < 0) got = k;
            end
            if (busy32 !== (k <= lat)) busy_bad++;
            if (k <= lat) tick();
        end
        check("ready_latency", 64'(got), 64'(lat));
        check("ready_pulses", 64'(rcnt), 64'd1);
        check("busy_window_bad_cycles", 64'(busy_bad), 64'd0);
    endtask

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int seen = 0;
        sgn8 = s; op1_8 = a; op2_8 = b; start8 = 1'b1;
        q8.push_back(ref8(s, a, b));
        tick();
        start8 = 1'b0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            if (ready8) seen = 1;
            tick();
        end
        check("ready8_timeout", 64'(seen), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic s;
        int rpos1, rpos2, rcnt;

        #2;
        check("reset_result", res32, 64'd0);
        check("reset_ready_busy", {62'd0, ready32, busy32}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        run32(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run32(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
        run32(1'b1, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 33);
        run32(1'b0, 32'd5, 32'd0, 64'd0, 1);
        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        run32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33);
        run32(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3}, 33);

        // Annul mid-flight, then restart in the very next cycle.
        sgn32 = 1'b0; op1_32 = 32'd100; op2_32 = 32'd7; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        repeat (9) tick();
        annul32 = 1'b1;
        tick();
        annul32 = 1'b0;
        check("annul_busy_low", {63'd0, busy32}, 64'd0);
        check("annul_no_ready", {63'd0, ready32}, 64'd0);
        run32(1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 33);

        // Annul coinciding with start: request dropped.
        sgn32 = 1'b0; op1_32 = 32'd50; op2_32 = 32'd5; start32 = 1'b1; annul32 = 1'b1;
        tick();
        start32 = 1'b0; annul32 = 1'b0;
        check("annul_with_start_busy", {63'd0, busy32}, 64'd0);
        tick();

        // Asynchronous reset in the middle of a division.
        op1_32 = 32'd100; op2_32 = 32'd7; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("midrst_result", res32, 64'd0);
        check("midrst_ready_busy", {62'd0, ready32, busy32}, 64'd0);
        tick();
        rst = 1'b0;
        rcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (ready32) rcnt++;
            tick();
        end
        check("post_reset_no_ready", 64'(rcnt), 64'd0);
        run32(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);

        // start held high across the ready pulse launches an identical division.
        sgn32 = 1'b0; op1_32 = 32'd100; op2_32 = 32'd7; start32 = 1'b1;
        q32.push_back({32'd2, 32'd14});
        q32.push_back({32'd2, 32'd14});
        rpos1 = -1; rpos2 = -1; rcnt = 0;
        for (int k = 1; k <= 67; k++) begin
            tick();
            if (ready32) begin
                rcnt++;
                if (rpos1 < 0) rpos1 = k; else rpos2 = k;
            end
        end
        start32 = 1'b0;
        tick();
        check("held_start_pulses", 64'(rcnt), 64'd2);
        check("held_start_first", 64'(rpos1), 64'd33);
        check("held_start_second", 64'(rpos2), 64'd67);
        check("held_start_idle", {63'd0, busy32}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 3 == 0) b = b >> 20;
            s = 1'($urandom_range(0, 1));
            run32(s, a, b, ref32(s, a, b), (b == 32'd0) ? 1 : 33);
        end

        run8(1'b1, 8'h80, 8'hFF);
        run8(1'b0, 8'h80, 8'hFF);
        run8(1'b1, 8'h9C, 8'h07);
        run8(1'b0, 8'd200, 8'd0);
        for (int i = 0; i < 24; i++) begin
            run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 255)));
        end

        repeat (3) tick();
        check("queue32_drained", 64'(q32.size()), 64'd0);
        check("queue8_drained", 64'(q8.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
